pool2_maxpool: RTL and testbench
================================

# pool2_maxpool

Second max-pool stage of the quickdraw CNN. It reads the 32×14×14 feature maps produced by `conv2` after its `done` pulse. Each map is reduced with a 2×2, stride-2 max window into a 32×7×7 result for the dense layers. It uses the same start/done handshake as the convolution stages and scans the input sequentially, one window element per cycle.

## Interface
- `CH`, default 32: number of channels (input and output).
- `IN_DIM`, default 14: input map height and width; must be even.
- `OUT_DIM`, default 7: output height and width; must equal IN_DIM/2.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately. Logic resumes on the first rising edge after deassertion.
- `start`, input, 1: level request to begin a pass; sampled only in IDLE.
- `conv2_maps`, input, signed 32 × [CH][IN_DIM][IN_DIM]: source maps. Must be held stable while `busy`=1.
- `done`, output, 1: high once a full pass has completed. Stays high until the next accepted `start`.
- `busy`, output, 1: high in every state except IDLE, DONE and WAIT_START_LOW.
- `pool2_maps`, output, signed 32 × [CH][OUT_DIM][OUT_DIM]: pooled result. Registered; each element is written once per pass.

## Operation
- Counters:
  - `c`: channel, 0..CH-1.
  - `r`, `q`: output row and column, 0..OUT_DIM-1.
  - `k`: window element, 0..3, visited in this order: (2r,2q), (2r,2q+1), (2r+1,2q), (2r+1,2q+1).
- Running maximum register `mx`, signed 32-bit. No ReLU, no saturation, no width change.
- Comparison is a signed greater-than. On a tie `mx` keeps its current value; for equal values either choice yields the same result.
- FSM states: IDLE, SCAN, WRITE, DONE, WAIT_START_LOW.
- IDLE: when `start`=1, clear `c`, `r`, `q`, `k` and `done`, then go to SCAN. Otherwise hold.
- SCAN, per cycle:
  - If k=0: load `mx` with element 0.
  - If k=1..3: `mx` <= max(`mx`, element k).
  - If k<3: k<=k+1 and stay in SCAN.
  - If k=3: k<=0 and go to WRITE.
- WRITE:
  - Write `pool2_maps[c][r][q]` <= `mx`.
  - Advance q. On wrap, q=0 and advance r. On r wrap, r=0 and advance c.
  - If (c,r,q) was (CH-1,OUT_DIM-1,OUT_DIM-1), go to DONE. Otherwise go to SCAN.
- DONE: set `done`<=1, then go to WAIT_START_LOW.
- WAIT_START_LOW: go to IDLE only when `start`=0. This prevents a held `start` from retriggering a pass.
- Reset values:
  - state=IDLE.
  - All counters=0 and `mx`=0.
  - `done`=0 and `busy`=0.
  - Every `pool2_maps` element=0.
- Reset mid-pass aborts immediately. Outputs return to the reset values; no partial-result retention is required.
- A `start` edge while `busy`=1 is ignored.
- Changing `conv2_maps` during a pass is illegal, and the result is undefined. The bench must not do it.

## Timing
- Per output element: 4 SCAN cycles + 1 WRITE cycle = 5 cycles.
- Accept edge: `start`=1 sampled in IDLE at edge E0. SCAN occupies edges E1..E4.
- The first output element, `pool2_maps[0][0][0]`, is visible after edge E5, the WRITE edge.
- Element n (0-based, in c-major, r, q order) updates at edge E0+5(n+1).
- The last WRITE is at E0+5·CH·OUT_DIM² = E0+7840 with defaults.
- DONE occupies the cycle after the last WRITE. `done` reads 1 after edge E0+7841.
- `busy` rises after E0 and falls after the last WRITE edge, when the FSM enters DONE.
- Minimum restart: `start` must be low for at least one sampled edge in WAIT_START_LOW. It is then accepted on a later IDLE edge.

## Test plan
- All 32×14×14 inputs = 5, `start` pulsed 1 cycle. Required:
  - every `pool2_maps` element = 5;
  - `done`=1 at E0+7841 and not before;
  - `busy` high for exactly 7840 cycles.
- Ramp input, `conv2_maps[c][i][j]` = c·1000 + i·14 + j. Required:
  - `pool2_maps[c][r][q]` = c·1000 + (2r+1)·14 + 2q+1;
  - `pool2_maps[3][6][6]` = 3195.
- Signed and position coverage, all inputs = -100 except window (0,0,0):
  - window elements = -7, -3, -9, -1 → `pool2_maps[0][0][0]` = -1 and all other elements = -100.
  - The maximum is then placed in each of the 4 window positions in turn → -1 every time.
- Hold `start`=1 for 20000 cycles. Required:
  - exactly one pass, with `done` staying 1;
  - dropping `start`, then raising it again, starts a second pass; `done` clears on the accept edge.
- Reset mid-pass: assert `reset`=0 at E0+3000. Required:
  - `done`=0, `busy`=0 and all outputs = 0 immediately, asynchronously;
  - after release, a fresh `start` produces the correct full result.
- Ties and extremes, window = {0x7FFFFFFF, 0x80000000, 0x7FFFFFFF, 0}: result = 0x7FFFFFFF.

Source files
------------

// File: rtl/pool2_maxpool_if.sv
// Handshake and map bus for the pool2 max-pool stage.
//   start      : level request to begin a pass (sampled only while idle)
//   done       : high once a full pass completed, until next accepted start
//   busy       : high while scanning/writing
//   conv2_maps : signed source maps [CH][IN_DIM][IN_DIM], stable while busy
//   pool2_maps : signed pooled maps [CH][OUT_DIM][OUT_DIM], registered
interface pool2_maxpool_if #(
  parameter int unsigned CH      = 32,
  parameter int unsigned IN_DIM  = 14,
  parameter int unsigned OUT_DIM = 7
);
  logic               start;
  logic               done;
  logic               busy;
  logic signed [31:0] conv2_maps [CH][IN_DIM][IN_DIM];
  logic signed [31:0] pool2_maps [CH][OUT_DIM][OUT_DIM];

  modport master (
    output start,
    output conv2_maps,
    input  done,
    input  busy,
    input  pool2_maps
  );

  modport slave (
    input  start,
    input  conv2_maps,
    output done,
    output busy,
    output pool2_maps
  );
endinterface

// File: rtl/pool2_maxpool.sv
// 2x2 stride-2 max pool over CH maps of IN_DIM x IN_DIM, one window element per cycle.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, clears all state including the result maps
//   bus   : slave side of pool2_maxpool_if (start/done/busy handshake, input/output maps)
// Each output element takes 4 SCAN cycles plus 1 WRITE cycle.
module pool2_maxpool #(
  parameter int unsigned CH      = 32,
  parameter int unsigned IN_DIM  = 14,
  parameter int unsigned OUT_DIM = 7
) (
  input logic              clk,
  input logic              reset,
  pool2_maxpool_if.slave   bus
);

  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned RW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int unsigned IW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

  localparam logic [CW-1:0] CMax = CW'(CH - 1);
  localparam logic [RW-1:0] RMax = RW'(OUT_DIM - 1);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StWrite,
    StDone,
    StWaitStartLow
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      c_q, c_d;
  logic [RW-1:0]      r_q, r_d;
  logic [RW-1:0]      q_q, q_d;
  logic [1:0]         k_q, k_d;
  logic signed [31:0] mx_q, mx_d;
  logic               done_q, done_d;
  logic               wr_en;

  logic signed [31:0] maps_q [CH][OUT_DIM][OUT_DIM];

  // Window element k sits at (2r + k[1], 2q + k[0]).
  logic [IW-1:0]      row_idx;
  logic [IW-1:0]      col_idx;
  logic signed [31:0] elem;

  assign row_idx = IW'({r_q, k_q[1]});
  assign col_idx = IW'({q_q, k_q[0]});
  assign elem    = bus.conv2_maps[c_q][row_idx][col_idx];

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    q_d     = q_q;
    k_d     = k_q;
    mx_d    = mx_q;
    done_d  = done_q;
    wr_en   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          c_d     = '0;
          r_d     = '0;
          q_d     = '0;
          k_d     = '0;
          done_d  = 1'b0;
          state_d = StScan;
        end
      end

      StScan: begin
        // Strict greater-than: ties keep the current maximum.
        if (k_q == 2'd0) begin
          mx_d = elem;
        end else if (elem > mx_q) begin
          mx_d = elem;
        end
        if (k_q == 2'd3) begin
          k_d     = '0;
          state_d = StWrite;
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      StWrite: begin
        wr_en = 1'b1;
        if (q_q == RMax) begin
          q_d = '0;
          if (r_q == RMax) begin
            r_d = '0;
            c_d = (c_q == CMax) ? '0 : c_q + 1'b1;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else begin
          q_d = q_q + 1'b1;
        end
        if (c_q == CMax && r_q == RMax && q_q == RMax) begin
          state_d = StDone;
        end else begin
          state_d = StScan;
        end
      end

      StDone: begin
        done_d  = 1'b1;
        state_d = StWaitStartLow;
      end

      StWaitStartLow: begin
        // A held start must not retrigger another pass.
        if (!bus.start) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      c_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      k_q     <= '0;
      mx_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      r_q     <= r_d;
      q_q     <= q_d;
      k_q     <= k_d;
      mx_q    <= mx_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(CH); i++) begin
        for (int j = 0; j < int'(OUT_DIM); j++) begin
          for (int m = 0; m < int'(OUT_DIM); m++) begin
            maps_q[i][j][m] <= '0;
          end
        end
      end
    end else if (wr_en) begin
      maps_q[c_q][r_q][q_q] <= mx_q;
    end
  end

  assign bus.done       = done_q;
  assign bus.busy       = (state_q == StScan) || (state_q == StWrite);
  assign bus.pool2_maps = maps_q;

endmodule

// File: tb/tb_pool2_maxpool.sv
// Self-checking bench for pool2_maxpool: scoreboard of expected pooled values, checked at
// each element's WRITE edge, plus handshake timing, held-start and mid-pass reset checks.
module tb_pool2_maxpool;

  localparam int unsigned CH      = 32;
  localparam int unsigned IN_DIM  = 14;
  localparam int unsigned OUT_DIM = 7;
  localparam int          NOUT    = CH * OUT_DIM * OUT_DIM;
  localparam int          PASS    = 5 * NOUT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool2_maxpool_if #(.CH(CH), .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM)) bus ();

  pool2_maxpool #(.CH(CH), .IN_DIM(IN_DIM), .OUT_DIM(OUT_DIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic signed [31:0] sb [$];

  task automatic check_eq(input string tag, input logic signed [31:0] got,
                          input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic fill_const(input logic signed [31:0] v);
    for (int c = 0; c < int'(CH); c++)
      for (int i = 0; i < int'(IN_DIM); i++)
        for (int j = 0; j < int'(IN_DIM); j++)
          bus.conv2_maps[c][i][j] = v;
  endtask

  function automatic logic signed [31:0] win_max(input int c, input int r, input int q);
    logic signed [31:0] m;
    m = bus.conv2_maps[c][2*r][2*q];
    for (int di = 0; di < 2; di++)
      for (int dj = 0; dj < 2; dj++)
        if (bus.conv2_maps[c][2*r+di][2*q+dj] > m) m = bus.conv2_maps[c][2*r+di][2*q+dj];
    return m;
  endfunction

  task automatic push_model();
    for (int c = 0; c < int'(CH); c++)
      for (int r = 0; r < int'(OUT_DIM); r++)
        for (int q = 0; q < int'(OUT_DIM); q++)
          sb.push_back(win_max(c, r, q));
  endtask

  // hold > 0 keeps start high for that many cycles counted from the accept edge.
  task automatic run_pass(input string name, input int hold);
    int   busy_cnt;
    bit   done_early;
    bit   bad_hold;
    int   n;
    int   c, r, q;
    logic signed [31:0] exp;
    busy_cnt   = 0;
    done_early = 0;
    bad_hold   = 0;
    n          = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check_eq({name, "_accept_busy"}, 32'(bus.busy), 32'd1);
    check_eq({name, "_accept_done"}, 32'(bus.done), 32'd0);
    busy_cnt += int'(bus.busy);
    if (hold == 0) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int t = 1; t <= PASS + 1; t++) begin
      @(posedge clk);
      #1;
      if (t <= PASS) begin
        if (bus.done) done_early = 1;
        if (t < PASS) busy_cnt += int'(bus.busy);
        else check_eq({name, "_busy_after_last_write"}, 32'(bus.busy), 32'd0);
        if (t % 5 == 0) begin
          c   = n / int'(OUT_DIM * OUT_DIM);
          r   = (n / int'(OUT_DIM)) % int'(OUT_DIM);
          q   = n % int'(OUT_DIM);
          exp = sb.pop_front();
          check_eq($sformatf("%s_elem[%0d][%0d][%0d]", name, c, r, q),
                   bus.pool2_maps[c][r][q], exp);
          n++;
        end
      end else begin
        check_eq({name, "_done_at_end"}, 32'(bus.done), 32'd1);
      end
    end
    check_eq({name, "_done_early"}, 32'(done_early), 32'd0);
    check_eq({name, "_busy_cycles"}, busy_cnt, PASS);
    if (hold > 0) begin
      for (int t = PASS + 2; t <= hold; t++) begin
        @(posedge clk);
        #1;
        if (bus.busy || !bus.done) bad_hold = 1;
      end
      check_eq({name, "_held_start_single_pass"}, 32'(bad_hold), 32'd0);
      check_eq({name, "_held_done"}, 32'(bus.done), 32'd1);
      @(negedge clk);
      bus.start = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  int nonzero;
  logic signed [31:0] e;

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    fill_const(32'sd0);
    #1;
    check_eq("reset_done", 32'(bus.done), 32'd0);
    check_eq("reset_busy", 32'(bus.busy), 32'd0);
    check_eq("reset_map_first", bus.pool2_maps[0][0][0], 32'sd0);
    check_eq("reset_map_last", bus.pool2_maps[CH-1][OUT_DIM-1][OUT_DIM-1], 32'sd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Constant 5.
    fill_const(32'sd5);
    for (int i = 0; i < NOUT; i++) sb.push_back(32'sd5);
    run_pass("const5", 0);

    // Ramp: max is always the bottom-right element of the window.
    for (int c = 0; c < int'(CH); c++)
      for (int i = 0; i < int'(IN_DIM); i++)
        for (int j = 0; j < int'(IN_DIM); j++)
          bus.conv2_maps[c][i][j] = 32'(c * 1000 + i * 14 + j);
    for (int c = 0; c < int'(CH); c++)
      for (int r = 0; r < int'(OUT_DIM); r++)
        for (int q = 0; q < int'(OUT_DIM); q++)
          sb.push_back(32'(c * 1000 + (2 * r + 1) * 14 + 2 * q + 1));
    run_pass("ramp", 0);
    check_eq("ramp_3_6_6", bus.pool2_maps[3][6][6], 32'sd3195);

    // Negatives, max in each window position, ties and extremes.
    fill_const(-32'sd100);
    bus.conv2_maps[0][0][0] = -32'sd7;
    bus.conv2_maps[0][0][1] = -32'sd3;
    bus.conv2_maps[0][1][0] = -32'sd9;
    bus.conv2_maps[0][1][1] = -32'sd1;
    for (int p = 0; p < 4; p++) begin
      bus.conv2_maps[1][0][2*p]   = -32'sd50;
      bus.conv2_maps[1][0][2*p+1] = -32'sd60;
      bus.conv2_maps[1][1][2*p]   = -32'sd70;
      bus.conv2_maps[1][1][2*p+1] = -32'sd80;
      bus.conv2_maps[1][p>>1][2*p+(p&1)] = -32'sd1;
    end
    bus.conv2_maps[2][0][0] = 32'sh7FFF_FFFF;
    bus.conv2_maps[2][0][1] = 32'sh8000_0000;
    bus.conv2_maps[2][1][0] = 32'sh7FFF_FFFF;
    bus.conv2_maps[2][1][1] = 32'sd0;
    for (int c = 0; c < int'(CH); c++)
      for (int r = 0; r < int'(OUT_DIM); r++)
        for (int q = 0; q < int'(OUT_DIM); q++) begin
          if (c == 0 && r == 0 && q == 0) e = -32'sd1;
          else if (c == 1 && r == 0 && q < 4) e = -32'sd1;
          else if (c == 2 && r == 0 && q == 0) e = 32'sh7FFF_FFFF;
          else e = -32'sd100;
          sb.push_back(e);
        end
    run_pass("signed", 0);

    // Random data with start held high for 20000 cycles.
    for (int c = 0; c < int'(CH); c++)
      for (int i = 0; i < int'(IN_DIM); i++)
        for (int j = 0; j < int'(IN_DIM); j++)
          bus.conv2_maps[c][i][j] = $signed($urandom());
    push_model();
    run_pass("hold", 20000);

    // Restart then reset mid-pass; done clears on the accept edge.
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    check_eq("restart_done_cleared", 32'(bus.done), 32'd0);
    check_eq("restart_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2999) @(posedge clk);
    #1;
    check_eq("midpass_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_map_first", bus.pool2_maps[0][0][0], 32'sd0);
    nonzero = 0;
    for (int c = 0; c < int'(CH); c++)
      for (int r = 0; r < int'(OUT_DIM); r++)
        for (int q = 0; q < int'(OUT_DIM); q++)
          if (bus.pool2_maps[c][r][q] != 0) nonzero++;
    check_eq("abort_maps_nonzero", nonzero, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    push_model();
    run_pass("after_reset", 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
